// File: rtl/bus_arb_pkg.sv
// Shared constants and state encoding for the 8-source round-robin word arbiter.
package bus_arb_pkg;

    localparam int unsigned NUM_SRC = 8;
    localparam int unsigned SRC_W   = 3;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/Mux8Bits.sv
// Shared 8:1 word mux on the source word path.
module Mux8Bits #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       selector,
    input  logic [WIDTH-1:0] in_0,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic [WIDTH-1:0] in_3,
    input  logic [WIDTH-1:0] in_4,
    input  logic [WIDTH-1:0] in_5,
    input  logic [WIDTH-1:0] in_6,
    input  logic [WIDTH-1:0] in_7,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = in_0;
        case (selector)
            3'd0: out = in_0;
            3'd1: out = in_1;
            3'd2: out = in_2;
            3'd3: out = in_3;
            3'd4: out = in_4;
            3'd5: out = in_5;
            3'd6: out = in_6;
            3'd7: out = in_7;
            default: out = in_0;
        endcase
    end

endmodule

// File: rtl/bus_arbiter8_rr_pick8.sv
// Round-robin pick: rotate req so ptr sits at bit 0, take the lowest set bit, un-rotate.
module rr_pick8
    import bus_arb_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [SRC_W-1:0]   winner,
    output logic               any
);

    logic [2*NUM_SRC-1:0] dbl;
    logic [NUM_SRC-1:0]   rot;
    logic [SRC_W-1:0]     idx;

    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[NUM_SRC-1:0];
        idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (rot[i]) idx = SRC_W'(i);
        end
        // 3-bit add wraps modulo 8, undoing the rotation
        winner = idx + ptr;
        any    = |req;
    end

endmodule

// File: rtl/bus_arbiter8.sv
// Round-robin arbiter/sequencer for the 8-source shared word path with a one-entry output stage.
// Optional per-grant burst limit enabled by defining BUS_ARB_BURST_LIMIT_EN.
module bus_arbiter8
    import bus_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_SRC-1:0]    req,
    input  logic [DATA_WIDTH-1:0] data_0,
    input  logic [DATA_WIDTH-1:0] data_1,
    input  logic [DATA_WIDTH-1:0] data_2,
    input  logic [DATA_WIDTH-1:0] data_3,
    input  logic [DATA_WIDTH-1:0] data_4,
    input  logic [DATA_WIDTH-1:0] data_5,
    input  logic [DATA_WIDTH-1:0] data_6,
    input  logic [DATA_WIDTH-1:0] data_7,
    output logic [NUM_SRC-1:0]    grant,
    output logic [NUM_SRC-1:0]    accept,
    output logic [SRC_W-1:0]      mux_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [SRC_W-1:0]      out_src,
    output logic                  busy
);

    arb_state_e            state;
    logic [SRC_W-1:0]      own;
    logic [SRC_W-1:0]      ptr;
    logic [SRC_W-1:0]      winner;
    logic                  any;
    logic [DATA_WIDTH-1:0] mux_out;
    logic                  space;
    logic                  take;
    logic                  burst_end;

    generate
        if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
            $error("MAX_BURST must be in 1..15");
        end
    endgenerate

    rr_pick8 u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (winner),
        .any    (any)
    );

    Mux8Bits #(.WIDTH(DATA_WIDTH)) u_mux (
        .selector (mux_sel),
        .in_0     (data_0),
        .in_1     (data_1),
        .in_2     (data_2),
        .in_3     (data_3),
        .in_4     (data_4),
        .in_5     (data_5),
        .in_6     (data_6),
        .in_7     (data_7),
        .out      (mux_out)
    );

    assign mux_sel = own;
    assign busy    = (state == ARB_BUSY);
    assign space   = !out_valid || out_ready;
    assign take    = busy && req[own] && space;
    assign accept  = (reset && take) ? grant : '0;

`ifdef BUS_ARB_BURST_LIMIT_EN
    logic [CNT_W-1:0] cnt;
    assign burst_end = take && ((cnt + CNT_W'(1)) == CNT_W'(MAX_BURST));
`else
    assign burst_end = 1'b0;
`endif

    // Owner FSM plus output stage; own is held in IDLE so mux_sel stays stable
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ARB_IDLE;
            grant     <= '0;
            own       <= '0;
            ptr       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
`ifdef BUS_ARB_BURST_LIMIT_EN
            cnt       <= '0;
`endif
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (any) begin
                        own   <= winner;
                        grant <= NUM_SRC'(1) << winner;
                        state <= ARB_BUSY;
`ifdef BUS_ARB_BURST_LIMIT_EN
                        cnt   <= '0;
`endif
                    end
                end
                ARB_BUSY: begin
                    if (take) begin
                        out_data  <= mux_out;
                        out_src   <= own;
                        out_valid <= 1'b1;
`ifdef BUS_ARB_BURST_LIMIT_EN
                        cnt       <= cnt + CNT_W'(1);
`endif
                    end
                    if (!req[own] || burst_end) begin
                        state <= ARB_IDLE;
                        grant <= '0;
                        ptr   <= own + SRC_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/bus_arbiter8.md
# bus_arbiter8

Round-robin arbiter and sequencer for the shared 32-bit, 8-source word path. Eight requesters each present a data word and a request. The arbiter grants one owner at a time, drives the 3-bit select of the shared 8:1 word mux (`Mux8Bits`), and registers the selected word into a single-entry valid/ready output stage. Downstream consumers see one serialized word stream tagged with its source index.

## Interface
- `DATA_WIDTH`, 32, width of each source word and of the output word.
- `MAX_BURST`, 4, maximum words per grant; range 1..15. Used only when the burst-limit macro is defined.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req`  in  8  per-source request; bit i means source i has a valid word on `data_i`.
- `data_0` .. `data_7`  in  DATA_WIDTH each  source words.
- `grant`  out  8  registered one-hot owner; all zeros when idle.
- `accept`  out  8  combinational one-hot; bit i high means `data_i` is consumed this cycle.
- `mux_sel`  out  3  owner index, driven to the shared mux select.
- `out_valid`  out  1  output stage holds a word.
- `out_ready`  in  1  downstream takes the word when `out_valid && out_ready`.
- `out_data`  out  DATA_WIDTH  registered word.
- `out_src`  out  3  source index of `out_data`.
- `busy`  out  1  FSM is in BUSY.

## Operation
- FSM has two states: IDLE and BUSY.
  - Owner register: `own[2:0]`.
  - Rotation pointer: `ptr[2:0]`.
  - Burst counter: `cnt[3:0]`.
- IDLE:
  - If `req != 0`, pick the winner. Search order is `ptr, ptr+1, …, ptr+7` mod 8, and the first set bit wins.
  - On the next edge: `own <= winner`, `grant <= onehot(winner)`, `cnt <= 0`, go to BUSY.
  - No word is consumed in IDLE.
- BUSY:
  - Define `space = !out_valid || out_ready`.
  - Define `take = req[own] && space`.
  - `accept = grant` when `take`, else 0.
  - On `take`: `out_data <= data_own`, `out_src <= own`, `out_valid <= 1`, `cnt <= cnt+1`.
  - If `out_ready && out_valid && !take`: `out_valid <= 0`.
- BUSY exit. Go to IDLE, with `grant <= 0` and `ptr <= own+1` (mod 8, so 7 wraps to 0), when either:
  - `req[own] == 0`, or
  - a `take` brings `cnt+1 == MAX_BURST` (macro-enabled only).
- In IDLE, the output stage keeps draining: `out_valid` clears on `out_ready`.
- `mux_sel = own` at all times. Its value is don't-care in IDLE but must be stable, so `own` is held.
- Other requests never preempt an owner mid-grant.
- Requester protocol:
  - A requester keeps `req` and `data` stable until it sees `accept`.
  - After the `accept` cycle it may present the next word or drop `req`.
- Reset (`reset == 0` at an edge) applies regardless of state, including mid-burst. In-flight `out_data` is discarded.
  - Reset values: state IDLE, `grant = 0`, `own = 0`, `ptr = 0`, `cnt = 0`, `out_valid = 0`, `out_data = 0`, `out_src = 0`, `busy = 0`.
  - `accept` is 0 while reset is asserted.

## Timing
- Latency from `req` rising in IDLE to `grant` is 1 edge. The first `accept` is possible in the cycle after that edge.
- Word throughput while BUSY with `out_ready` held high is 1 word/cycle.
- Each owner change costs exactly one IDLE bubble cycle.
- `out_data` appears 1 edge after `accept`.
- If `req[own]` drops and `out_ready` is asserted in the same cycle, the held word still drains and the FSM goes to IDLE.
- Backpressure: with `out_valid=1` and `out_ready=0`, `space=0`. There is no `take`, and `cnt` and `out_data` stay frozen.

## Configuration
- `BUS_ARB_BURST_LIMIT_EN` defined: `cnt` is implemented, and the grant ends after `MAX_BURST` takes even if `req[own]` stays high. The ex-owner gets the lowest priority at the next arbitration.
- `BUS_ARB_BURST_LIMIT_EN` undefined: the grant is held until `req[own]` drops. `cnt` is removed and `MAX_BURST` is ignored.

## Structure
- Package/header `bus_arb_pkg`: state encoding constants (`ARB_IDLE=1'b0`, `ARB_BUSY=1'b1`), `NUM_SRC=8`, `SRC_W=3`.
- Sub-module `rr_pick8`: combinational.
  - Inputs: `req[7:0]`, `ptr[2:0]`.
  - Outputs: `winner[2:0]`, `any`.
  - Implemented as a rotate, priority encode, then un-rotate.
- The shared `Mux8Bits` is instantiated inside, with `selector = mux_sel`. Its output feeds the `out_data` register.

## Test plan
- Single source: `req=8'h04`, `data_2=32'hA5A5_0001`, `out_ready=1`.
  - `grant=8'h04` after 1 edge.
  - `out_data=32'hA5A5_0001`, `out_src=2` one edge after `accept`.
- Round-robin wrap: all `req=8'hFF`, each asserted for one word then dropped.
  - Grant order 0,1,…,7.
  - Then `req` re-raised for sources 7 and 0: order 0 then 7, because `ptr` wrapped to 0.
- Backpressure: owner 5 streaming, `out_ready=0` for 3 cycles.
  - `accept=0`, `out_data` held, `cnt` frozen.
  - On `out_ready=1`, the stream resumes with no word lost or duplicated.
- Burst limit (macro on, `MAX_BURST=4`): `req=8'h03` held high.
  - Source 0 gets exactly 4 words, then one IDLE cycle, then source 1 gets 4.
  - With macro off, source 0 keeps the grant indefinitely.
- Reset mid-burst: pull `reset` low during owner 3's second word.
  - Next edge: `grant=0`, `out_valid=0`, `ptr=0`, `busy=0`.
  - After release with `req=8'h08`: `grant=8'h08` again.
